alu_mc: RTL
===========

Name: alu_mc

Overview:
- Parametrised, handshaked successor to the single-cycle 32-bit ALU.
- Registers all results and flags. Adds SUB, SLT, and multi-cycle shifts (one bit position per cycle), plus an optional iterative multiply.
- Sits between the decode/operand stage and writeback in the lab CPU datapath.
- Uses valid/ready on both sides, so multi-cycle ops stall the producer cleanly.

Parameters:
- WIDTH, 32, operand/result width; power of two, >= 4. Shift amount width SW = clog2(WIDTH) is a derived localparam.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset, asynchronous, active-low
- in_valid  in  1  operands/op valid
- in_ready  out  1  block can accept an operation
- src1  in  WIDTH  operand A
- src2  in  WIDTH  operand B; shift ops use src2[SW-1:0] as shamt
- alu_ctrl  in  4  operation select
- out_valid  out  1  result/flags valid
- out_ready  in  1  consumer accepts result
- result  out  WIDTH  result
- zero  out  1  result == 0
- cout  out  1  carry out of MSB (ADD/SUB only)
- overflow  out  1  signed overflow (ADD/SUB only)
- err  out  1  illegal alu_ctrl

Behaviour:
- Reset (async, rst_n low): state IDLE; in_ready=0 while rst_n is low, 1 from the first clk edge after release; out_valid=0; result=0; zero=0; cout=0; overflow=0; err=0. Reset mid-operation aborts it; the partial result is discarded.
- Op codes:
  - 0000 AND; 0001 OR; 1100 NOR.
  - 0010 ADD; 0110 SUB, computed as A + ~B + 1.
  - 0111 SLT: signed compare, result = {0..0, lt}; correct even when A-B overflows.
  - 1000 SLL; 1001 SRL; 1010 SRA.
  - 1011 MUL: low WIDTH bits, only with the optional feature.
  - Any other code is illegal.
- FSM IDLE -> EXEC -> DONE:
  - IDLE: in_ready=1. On in_valid, latch operands/op.
  - Single-cycle op or illegal op: go to DONE. Result is registered, out_valid=1 on the next cycle (latency 1).
  - Shift: if shamt==0, go to DONE with result=src1 (latency 1). Otherwise go to EXEC with counter=shamt; each EXEC cycle shifts the working register by 1 (SRA replicates MSB) and decrements the counter. At counter==1, go to DONE. Latency = shamt+1 cycles.
  - EXEC: in_ready=0; in_valid is ignored.
  - DONE: out_valid=1; result and flags held stable while out_ready=0. On out_ready=1, go to IDLE; in_ready is 1 on the following cycle. Max throughput is 1 op per 2 cycles.
- Flags, all registered with result:
  - zero = (result==0) for every op, including illegal ops.
  - cout: ADD carry out of bit WIDTH-1; SUB carry of A+~B+1 (1 = no borrow); else 0.
  - overflow: ADD = (A[msb]==B[msb]) && (R[msb]!=A[msb]); SUB = (A[msb]!=B[msb]) && (R[msb]!=A[msb]); else 0.
  - err: 1 only for an illegal op. Illegal op gives result=0, zero=1, cout=0, overflow=0.
- Simultaneous events:
  - in_valid while not IDLE: not accepted; the producer must hold its inputs.
  - out_ready with out_valid=0: ignored.

Optional Feature:
- Macro ALU_MC_MUL_EN.
- Defined: op 1011 = unsigned shift-add multiply. Takes WIDTH EXEC cycles (one multiplier bit per cycle), so latency = WIDTH+1. Result = low WIDTH bits of the product; cout=0, overflow=0.
- Not defined: 1011 is illegal (err=1, latency 1); no multiplier datapath is instantiated.

Test Plan:
- Reset, then ADD 0x7FFFFFFF + 0x00000001 (WIDTH=32) -> one cycle later out_valid=1, result=0x80000000, overflow=1, cout=0, zero=0.
- SUB 5-5 -> result=0, zero=1, cout=1, overflow=0. SLT 0x80000000 vs 0x00000001 -> result=1.
- SRA src1=0xF0000000, shamt=4 -> out_valid exactly 5 cycles after acceptance, result=0xFF000000. SLL with shamt=0 -> result=src1, latency 1.
- Hold out_ready=0 for 3 cycles after an OR -> result/flags stable, in_ready=0 throughout; in_ready=1 the cycle after out_ready pulses.
- alu_ctrl=1111 -> err=1, result=0, zero=1. Assert rst_n low during an SRL with shamt=31 -> outputs clear immediately; after release, in_ready=1 and the next ADD is correct.
- With ALU_MC_MUL_EN: MUL 0x0000FFFF * 0x00010001 -> result=0xFFFFFFFF after 33 cycles. Without the macro: same op gives err=1.

Source files
------------

// File: rtl/alu_mc.sv
// Handshaked multi-cycle ALU: registered result/flags, bit-serial shifts.
// Define ALU_MC_MUL_EN to add an iterative shift-add multiply on op 1011.
module alu_mc #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] src1,
  input  logic [WIDTH-1:0] src2,
  input  logic [3:0]       alu_ctrl,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             cout,
  output logic             overflow,
  output logic             err
);

  localparam int unsigned SW  = $clog2(WIDTH);
  localparam int unsigned CW  = SW + 1;
  localparam int unsigned MSB = WIDTH - 1;

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_SLT = 4'b0111;
  localparam logic [3:0] OP_SLL = 4'b1000;
  localparam logic [3:0] OP_SRL = 4'b1001;
  localparam logic [3:0] OP_SRA = 4'b1010;
  localparam logic [3:0] OP_NOR = 4'b1100;
`ifdef ALU_MC_MUL_EN
  localparam logic [3:0] OP_MUL = 4'b1011;
`endif

  typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, DONE = 2'd2} state_t;

  state_t           state_q, state_d;
  logic [3:0]       op_q;
  logic [WIDTH-1:0] work_q;
  logic [CW-1:0]    cnt_q;

  logic [SW-1:0]    shamt_c;
  logic             accept_c, is_shift_c, is_mul_c, start_exec_c, last_c;
  logic [WIDTH:0]   add_c, sub_c;
  logic             lt_c;
  logic [WIDTH-1:0] sc_res_c, step_c, exec_res_c, res_d;
  logic             sc_cout_c, sc_ovf_c, sc_err_c;
  logic             cout_d, ovf_d, err_d, load_res_c;
  logic             in_ready_d, out_valid_d;

  assign shamt_c      = src2[SW-1:0];
  assign accept_c     = (state_q == IDLE) && in_ready && in_valid;
  assign is_shift_c   = alu_ctrl inside {OP_SLL, OP_SRL, OP_SRA};
`ifdef ALU_MC_MUL_EN
  assign is_mul_c     = (alu_ctrl == OP_MUL);
`else
  assign is_mul_c     = 1'b0;
`endif
  assign start_exec_c = (is_shift_c && (shamt_c != '0)) || is_mul_c;
  assign last_c       = (cnt_q == CW'(1));

  // Single-cycle datapath; SUB is A + ~B + 1 so cout means "no borrow"
  assign add_c = {1'b0, src1} + {1'b0, src2};
  assign sub_c = {1'b0, src1} + {1'b0, ~src2} + (WIDTH+1)'(1);
  // Differing signs decide SLT directly, so A-B overflow cannot corrupt it
  assign lt_c  = (src1[MSB] != src2[MSB]) ? src1[MSB] : sub_c[MSB];

  always_comb begin
    sc_res_c  = '0;
    sc_cout_c = 1'b0;
    sc_ovf_c  = 1'b0;
    sc_err_c  = 1'b0;
    case (alu_ctrl)
      OP_AND: sc_res_c = src1 & src2;
      OP_OR:  sc_res_c = src1 | src2;
      OP_NOR: sc_res_c = ~(src1 | src2);
      OP_ADD: begin
        sc_res_c  = add_c[MSB:0];
        sc_cout_c = add_c[WIDTH];
        sc_ovf_c  = (src1[MSB] == src2[MSB]) && (add_c[MSB] != src1[MSB]);
      end
      OP_SUB: begin
        sc_res_c  = sub_c[MSB:0];
        sc_cout_c = sub_c[WIDTH];
        sc_ovf_c  = (src1[MSB] != src2[MSB]) && (sub_c[MSB] != src1[MSB]);
      end
      OP_SLT: sc_res_c = WIDTH'(lt_c);
      OP_SLL, OP_SRL, OP_SRA: sc_res_c = src1;
`ifdef ALU_MC_MUL_EN
      OP_MUL: sc_res_c = '0;
`endif
      default: sc_err_c = 1'b1;
    endcase
  end

  // One iteration of the serial engine: shift by one bit, or advance multiplicand
  always_comb begin
    step_c = work_q;
    case (op_q)
      OP_SLL: step_c = work_q << 1;
      OP_SRL: step_c = work_q >> 1;
      OP_SRA: step_c = {work_q[MSB], work_q[MSB:1]};
`ifdef ALU_MC_MUL_EN
      OP_MUL: step_c = work_q << 1;
`endif
      default: step_c = work_q;
    endcase
  end

`ifdef ALU_MC_MUL_EN
  logic [WIDTH-1:0] acc_q, mplier_q, acc_step_c;

  assign acc_step_c = acc_q + (mplier_q[0] ? work_q : '0);
  assign exec_res_c = (op_q == OP_MUL) ? acc_step_c : step_c;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q    <= '0;
      mplier_q <= '0;
    end else if (accept_c) begin
      acc_q    <= '0;
      mplier_q <= src2;
    end else if (state_q == EXEC) begin
      acc_q    <= acc_step_c;
      mplier_q <= mplier_q >> 1;
    end
  end
`else
  assign exec_res_c = step_c;
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept_c) state_d = start_exec_c ? EXEC : DONE;
      EXEC:    if (last_c) state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output logic: next values for the registered handshake and result/flags
  always_comb begin
    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_d == DONE);
    load_res_c  = 1'b0;
    res_d       = sc_res_c;
    cout_d      = sc_cout_c;
    ovf_d       = sc_ovf_c;
    err_d       = sc_err_c;
    case (state_q)
      IDLE: load_res_c = accept_c && !start_exec_c;
      EXEC: begin
        if (last_c) begin
          load_res_c = 1'b1;
          res_d      = exec_res_c;
          cout_d     = 1'b0;
          ovf_d      = 1'b0;
          err_d      = 1'b0;
        end
      end
      default: load_res_c = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      result    <= '0;
      zero      <= 1'b0;
      cout      <= 1'b0;
      overflow  <= 1'b0;
      err       <= 1'b0;
    end else begin
      in_ready  <= in_ready_d;
      out_valid <= out_valid_d;
      if (load_res_c) begin
        result   <= res_d;
        zero     <= (res_d == '0);
        cout     <= cout_d;
        overflow <= ovf_d;
        err      <= err_d;
      end
    end
  end

  // Operand latch and iteration counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q   <= '0;
      work_q <= '0;
      cnt_q  <= '0;
    end else if (accept_c) begin
      op_q   <= alu_ctrl;
      work_q <= src1;
      cnt_q  <= is_mul_c ? CW'(WIDTH) : CW'(shamt_c);
    end else if (state_q == EXEC) begin
      work_q <= step_c;
      cnt_q  <= cnt_q - CW'(1);
    end
  end

endmodule
